food_gen: RTL and testbench



---
 rtl/food_gen.sv | 129 ++++++++++++
 tb/tb_food_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/food_gen.sv
// rtl/food_gen.sv - food placement, eat detection and score for the snake pipeline; FOOD_BLINK_EN adds blinking
module food_gen #(
    parameter int          CELL_SHIFT = 4,
    parameter int          GRID_COLS  = 40,
    parameter int          GRID_ROWS  = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_TRIES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [5:0] head_col,
    input  logic [4:0] head_row,
    input  logic       head_valid,
    input  logic       game_over,
    input  logic       frame_tick,
    output logic       food_prnt,
    output logic [5:0] food_col,
    output logic [4:0] food_row,
    output logic       eaten,
    output logic [7:0] score
);

    localparam logic [0:0] SEEK   = 1'b0;
    localparam logic [0:0] PLACED = 1'b1;

    localparam int              TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [5:0]      COL_MAX  = 6'(GRID_COLS - 2);
    localparam logic [4:0]      ROW_MAX  = 5'(GRID_ROWS - 2);
    localparam logic [5:0]      COL_MID  = 6'(GRID_COLS / 2);
    localparam logic [4:0]      ROW_MID  = 5'(GRID_ROWS / 2);

    logic [15:0]      lfsr;
    logic             feedback;
    logic [0:0]       state;
    logic [TRY_W-1:0] tries;
    logic [5:0]       candCol;
    logic [4:0]       candRow;
    logic             candLegal;
    logic             headHit;
    logic [9:0]       cellX;
    logic [9:0]       cellY;
    logic             pixHit;
    logic             blinkOn;

    assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign candCol   = lfsr[5:0];
    assign candRow   = lfsr[12:8];
    // Border cells and out-of-grid codes are both rejected here.
    assign candLegal = (candCol != 6'd0) && (candCol <= COL_MAX) &&
                       (candRow != 5'd0) && (candRow <= ROW_MAX);

    assign headHit = (state == PLACED) && head_valid && !game_over &&
                     (head_col == food_col) && (head_row == food_row);

    assign cellX  = pixel_x >> CELL_SHIFT;
    assign cellY  = pixel_y >> CELL_SHIFT;
    assign pixHit = video_on && (state == PLACED) &&
                    (cellX == {4'd0, food_col}) && (cellY == {5'd0, food_row});

`ifdef FOOD_BLINK_EN
    logic [4:0] frameCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frameCnt <= 5'd0;
        end else if (headHit) begin
            frameCnt <= 5'd0;
        end else if (frame_tick) begin
            frameCnt <= frameCnt + 5'd1;
        end
    end

    assign blinkOn = ~frameCnt[4];
`else
    logic unusedTick;

    assign unusedTick = frame_tick;
    assign blinkOn    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= LFSR_SEED;
            state     <= SEEK;
            tries     <= '0;
            food_col  <= 6'd0;
            food_row  <= 5'd0;
            eaten     <= 1'b0;
            score     <= 8'd0;
            food_prnt <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], feedback};
            eaten     <= headHit;
            food_prnt <= pixHit & blinkOn;
            case (state)
                SEEK: begin
                    if (candLegal) begin
                        food_col <= candCol;
                        food_row <= candRow;
                        tries    <= '0;
                        state    <= PLACED;
                    end else if (tries == TRY_LAST) begin
                        // Bounded search: fall back to the playfield centre.
                        food_col <= COL_MID;
                        food_row <= ROW_MID;
                        tries    <= '0;
                        state    <= PLACED;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                PLACED: begin
                    if (headHit) begin
                        state <= SEEK;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                end
                default: state <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_food_gen.sv
// tb/tb_food_gen.sv - self-checking bench for food_gen against a cycle model
module tb_food_gen;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic [5:0] head_col = 6'd0;
    logic [4:0] head_row = 5'd0;
    logic       head_valid = 1'b0;
    logic       game_over = 1'b0;
    logic       frame_tick = 1'b0;
    logic       food_prnt;
    logic [5:0] food_col;
    logic [4:0] food_row;
    logic       eaten;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;

    int mLfsr, mTries, mCol, mRow, mScore, mFrame;
    bit mPlaced, mEaten, mPrnt;

    food_gen dut (
        .clk(clk), .rst(rstN), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .head_col(head_col), .head_row(head_row), .head_valid(head_valid),
        .game_over(game_over), .frame_tick(frame_tick), .food_prnt(food_prnt),
        .food_col(food_col), .food_row(food_row), .eaten(eaten), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int lfsrNext(input int l);
        return ((l << 1) & 16'hFFFF) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1);
    endfunction

    function automatic bit legalCell(input int c, input int r);
        return (c >= 1) && (c <= 38) && (r >= 1) && (r <= 28);
    endfunction

    function automatic bit eatNow();
        return mPlaced && head_valid && !game_over && (int'(head_col) == mCol) && (int'(head_row) == mRow);
    endfunction

    function automatic bit blinkVisible();
`ifdef FOOD_BLINK_EN
        return mFrame < 16;
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: what each output must be after every clock edge.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mLfsr <= 16'hACE1; mTries <= 0; mCol <= 0; mRow <= 0; mScore <= 0;
            mFrame <= 0; mPlaced <= 1'b0; mEaten <= 1'b0; mPrnt <= 1'b0;
        end else begin
            mLfsr  <= lfsrNext(mLfsr);
            mEaten <= eatNow();
            mPrnt  <= video_on && mPlaced && (int'(pixel_x) / 16 == mCol) &&
                      (int'(pixel_y) / 16 == mRow) && blinkVisible();
            if (eatNow()) mFrame <= 0;
            else if (frame_tick) mFrame <= (mFrame + 1) % 32;
            if (!mPlaced) begin
                if (legalCell(mLfsr % 64, (mLfsr / 256) % 32)) begin
                    mCol <= mLfsr % 64; mRow <= (mLfsr / 256) % 32; mPlaced <= 1'b1; mTries <= 0;
                end else if (mTries == 63) begin
                    mCol <= 20; mRow <= 15; mPlaced <= 1'b1; mTries <= 0;
                end else begin
                    mTries <= mTries + 1;
                end
            end else if (eatNow()) begin
                mPlaced <= 1'b0;
                mScore  <= (mScore < 255) ? mScore + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        check("food_prnt", food_prnt, mPrnt);
        check("eaten", eaten, mEaten);
        check("score", score, mScore);
        check("food_col", food_col, mCol);
        check("food_row", food_row, mRow);
        if (rstN && mPlaced) begin
            check("col_in_field", (food_col >= 1 && food_col <= 38), 1);
            check("row_in_field", (food_row >= 1 && food_row <= 28), 1);
        end
    end

    task automatic waitPlaced();
        for (int i = 0; i < 70; i++) begin
            if (mPlaced) break;
            @(negedge clk);
        end
        #1 check("placed_in_time", mPlaced, 1);
    endtask

    task automatic strobeHead(input int c, input int r);
        @(negedge clk);
        head_col = 6'(c); head_row = 5'(r); head_valid = 1'b1;
        @(negedge clk);
        head_valid = 1'b0;
        #1;
    endtask

    task automatic pulseTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    initial begin
        int savedCol, savedRow;
        repeat (3) @(negedge clk);
        #1;
        check("rst_score", score, 0);
        check("rst_eaten", eaten, 0);
        check("rst_food_col", food_col, 0);
        check("rst_food_prnt", food_prnt, 0);

        @(negedge clk) rstN = 1'b1;
        @(negedge clk);
        #1;
        check("first_col", food_col, 33);
        check("first_row", food_row, 12);

        @(negedge clk);
        video_on = 1'b1; pixel_x = 10'(33 * 16 + 5); pixel_y = 10'(12 * 16 + 15);
        @(negedge clk) #1 check("prnt_hit", food_prnt, 1);
        pixel_x = 10'(33 * 16 + 16);
        @(negedge clk) #1 check("prnt_next_cell", food_prnt, 0);
        pixel_x = 10'(33 * 16 + 5); video_on = 1'b0;
        @(negedge clk) #1 check("prnt_video_off", food_prnt, 0);
        video_on = 1'b1;
        @(negedge clk) #1 check("prnt_back_on", food_prnt, 1);

        pulseTicks(16);
        @(negedge clk) #1;
`ifdef FOOD_BLINK_EN
        check("blink_hidden", food_prnt, 0);
`else
        check("tick_ignored", food_prnt, 1);
`endif
        pulseTicks(16);
        @(negedge clk) #1 check("blink_restored", food_prnt, 1);
        video_on = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;

        strobeHead(33, 12);
        check("eat_pulse", eaten, 1);
        check("eat_score", score, 1);
        check("eat_prnt_off", food_prnt, 0);
        @(negedge clk) #1 check("eat_one_cycle", eaten, 0);
        waitPlaced();

        strobeHead(mCol + 1, mRow);
        check("offby1_no_eat", eaten, 0);
        check("offby1_score", score, 1);

        savedCol = mCol; savedRow = mRow;
        game_over = 1'b1;
        strobeHead(savedCol, savedRow);
        check("gameover_no_eat", eaten, 0);
        check("gameover_score", score, 1);
        check("gameover_col", food_col, savedCol);
        check("gameover_row", food_row, savedRow);
        game_over = 1'b0;
        strobeHead(savedCol, savedRow);
        check("resume_eat", eaten, 1);
        check("resume_score", score, 2);

        for (int i = 0; i < 253; i++) begin
            waitPlaced();
            strobeHead(mCol, mRow);
        end
        check("score_full", score, 255);
        waitPlaced();
        strobeHead(mCol, mRow);
        check("sat_eaten", eaten, 1);
        check("sat_score", score, 255);

        rstN = 1'b0;
        #1;
        check("async_rst_eaten", eaten, 0);
        check("async_rst_score", score, 0);
        check("async_rst_col", food_col, 0);
        @(negedge clk) rstN = 1'b1;
        @(negedge clk) #1;
        check("reseed_col", food_col, 33);
        check("reseed_row", food_row, 12);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
